// File: rtl/window_extremum_reduce_if.sv
// Valid/ready bundle for the window extremum reducer: input window beat and output pixel.
interface window_extremum_reduce_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TAPS       = 9
);
  logic                       s_valid;
  logic                       s_ready;
  logic [TAPS*DATA_WIDTH-1:0] s_data;
  logic [TAPS-1:0]            s_mask;
  logic                       s_mode;
  logic                       s_last;
  logic                       m_valid;
  logic                       m_ready;
  logic [DATA_WIDTH-1:0]      m_data;
  logic                       m_last;
  logic                       m_empty;

  modport master (
    output s_valid, s_data, s_mask, s_mode, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_empty
  );

  modport slave (
    input  s_valid, s_data, s_mask, s_mode, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, m_empty
  );
endinterface

// File: rtl/window_extremum_reduce.sv
// Reduces a masked window of signed taps to its min (erode) or max (dilate) through a
// registered compare tree: one leaf register stage plus ceil(log2(TAPS)) compare stages.
module window_extremum_reduce #(
  parameter int DATA_WIDTH = 16,
  parameter int TAPS       = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  window_extremum_reduce_if.slave   bus
);
  localparam int unsigned LEVELS = $clog2(TAPS);
  localparam int unsigned LEAVES = 1 << LEVELS;
  localparam logic [DATA_WIDTH-1:0] ERODE_ID  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] DILATE_ID = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic                  en;
  logic [DATA_WIDTH-1:0] in_id;

  assign en          = !bus.m_valid || bus.m_ready;
  assign bus.s_ready = en;
  assign in_id       = bus.s_mode ? DILATE_ID : ERODE_ID;

  // Level 0 registers the masked leaves, padded to a power of two with the identity value;
  // level l holds LEAVES>>l partial results of the beat that entered l cycles earlier.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned N = LEAVES >> l;

    logic v, last, empty;
    logic nv, nmode, nlast, nempty;

    if (l == 0) begin : g_src_in
      assign nv     = bus.s_valid;
      assign nmode  = bus.s_mode;
      assign nlast  = bus.s_last;
      assign nempty = ~|bus.s_mask;
    end else begin : g_src_prev
      assign nv     = g_lvl[l-1].v;
      assign nmode  = g_lvl[l-1].g_mode.mode;
      assign nlast  = g_lvl[l-1].last;
      assign nempty = g_lvl[l-1].empty;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v     <= 1'b0;
        last  <= 1'b0;
        empty <= 1'b0;
      end else if (en) begin
        v     <= nv;
        last  <= nlast;
        empty <= nempty;
      end
    end

    // The final stage has no consumer for mode, so it is only kept where a compare follows.
    if (l < LEVELS) begin : g_mode
      logic mode;
      always_ff @(posedge clk) begin
        if (rst)     mode <= 1'b0;
        else if (en) mode <= nmode;
      end
    end

    for (genvar j = 0; j < N; j++) begin : g_node
      logic [DATA_WIDTH-1:0] nxt, q;

      if (l == 0) begin : g_leaf
        if (j < TAPS) begin : g_tap
          assign nxt = bus.s_mask[j] ? bus.s_data[j*DATA_WIDTH +: DATA_WIDTH] : in_id;
        end else begin : g_pad
          assign nxt = in_id;
        end
      end else begin : g_pair
        logic [DATA_WIDTH-1:0] a, b;
        assign a = g_lvl[l-1].g_node[2*j].q;
        assign b = g_lvl[l-1].g_node[2*j+1].q;
        // Ties keep the lower-index operand a.
        assign nxt = g_lvl[l-1].g_mode.mode
                   ? (($signed(b) > $signed(a)) ? b : a)
                   : (($signed(b) < $signed(a)) ? b : a);
      end

      always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (en) q <= nxt;
      end
    end
  end

  assign bus.m_valid = g_lvl[LEVELS].v;
  assign bus.m_data  = g_lvl[LEVELS].g_node[0].q;
  assign bus.m_last  = g_lvl[LEVELS].last;
  assign bus.m_empty = g_lvl[LEVELS].empty;
endmodule
